// File: rtl/funct_generator_fifo.sv
// rtl/funct_generator_fifo.sv - single-clock sample FIFO behind the function generator
// Define FUNCT_GENERATOR_FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module funct_generator_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_TH  = 14,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);

  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH >= ALMOST_FULL_TH || ALMOST_FULL_TH > DEPTH)
  begin : g_th_check
    $error("funct_generator_fifo: thresholds must satisfy 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  // Flags come only from the registered count, never from the enables.
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_TH_C);
  assign almost_empty_o = (count_q <= AE_TH_C);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    // A new error in the same cycle as a clear must survive the clear.
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en_i && full_o)  overflow_d  = 1'b1;
    if (rd_en_i && empty_o) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_i;
  end

`ifdef FUNCT_GENERATOR_FIFO_FWFT_EN
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)         data_q <= '0;
    else if (rd_acc) data_q <= mem_q[rd_ptr_q];
  end

  assign data_o = data_q;
`endif

endmodule

// File: tb/tb_funct_generator_fifo.sv
// tb/tb_funct_generator_fifo.sv - self-checking bench for funct_generator_fifo
module tb_funct_generator_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [31:0] data_i;
  logic        rd_en_i;
  logic        clr_err_i;
  logic [31:0] data_o;
  logic        full_o;
  logic        empty_o;
  logic        almost_full_o;
  logic        almost_empty_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  funct_generator_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en_i),
    .data_i         (data_i),
    .rd_en_i        (rd_en_i),
    .clr_err_i      (clr_err_i),
    .data_o         (data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_model [$];
  logic [31:0] sb_q [$];
  logic [31:0] last_data;
  logic        ovf_m;
  logic        udf_m;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        clr;
    int          count;
    logic        ovf;
    logic        udf;
    logic [31:0] data_std;
    logic [31:0] data_fwft;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input int cnt);
    chk("count", 32'(count_o), 32'(cnt));
    chk("full", 32'(full_o), 32'(cnt == 16));
    chk("empty", 32'(empty_o), 32'(cnt == 0));
    chk("almost_full", 32'(almost_full_o), 32'(cnt >= 14));
    chk("almost_empty", 32'(almost_empty_o), 32'(cnt <= 2));
  endtask

  // One clock of stimulus; the reference model predicts everything visible after the edge.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
    int cnt;
    logic wacc, racc;
    logic [31:0] exp;
    cnt  = q_model.size();
    wacc = wr && (cnt < 16);
    racc = rd && (cnt > 0);
    wr_en_i   = wr;
    data_i    = d;
    rd_en_i   = rd;
    clr_err_i = clr;
    if (racc) sb_q.push_back(q_model.pop_front());
    if (wacc) q_model.push_back(d);
    if (clr) begin
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end
    if (wr && cnt == 16) ovf_m = 1'b1;
    if (rd && cnt == 0)  udf_m = 1'b1;
    @(posedge clk);
    #1;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    clr_err_i = 1'b0;
    chk_flags(q_model.size());
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    chk("underflow", 32'(underflow_o), 32'(udf_m));
`ifdef FUNCT_GENERATOR_FIFO_FWFT_EN
    if (racc) void'(sb_q.pop_front());
    exp = (q_model.size() > 0) ? q_model[0] : 32'h0;
    chk("data_fwft", data_o, exp);
`else
    if (racc) begin
      exp = sb_q.pop_front();
      last_data = exp;
      chk("data_read", data_o, exp);
    end else begin
      chk("data_hold", data_o, last_data);
    end
`endif
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    clr_err_i = 1'b0;
    data_i    = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_model.delete();
    sb_q.delete();
    ovf_m     = 1'b0;
    udf_m     = 1'b0;
    last_data = 32'h0;
    chk_flags(0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);
    chk("rst_underflow", 32'(underflow_o), 32'h0);
    chk("rst_data", data_o, 32'h0);
  endtask

  initial begin
    // Underflow with simultaneous write, sticky clear and set-wins-over-clear.
    tbl[0] = '{1'b1, 32'h55, 1'b1, 1'b0, 1, 1'b0, 1'b1, 32'h10, 32'h55};
    tbl[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 1, 1'b0, 1'b1, 32'h10, 32'h55};
    tbl[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h55, 32'h0};
    tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h55, 32'h0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h55, 32'h0};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h55, 32'h0};

    rst = 1'b1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clr_err_i = 1'b0;
    data_i = 32'h0;
    @(posedge clk);
    do_reset();

    // Fill 0x1..0x10.
    for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full_o), 32'h1);

    // Overflow while full; flag sticks until cleared.
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Drain; scoreboard expects 0x1..0x10 and never 0xDEADBEEF.
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty_o), 32'h1);

    for (int i = 0; i < 6; i++) begin
      wr_en_i   = tbl[i].wr;
      data_i    = tbl[i].din;
      rd_en_i   = tbl[i].rd;
      clr_err_i = tbl[i].clr;
      @(posedge clk);
      #1;
      chk_flags(tbl[i].count);
      chk("tbl_overflow", 32'(overflow_o), 32'(tbl[i].ovf));
      chk("tbl_underflow", 32'(underflow_o), 32'(tbl[i].udf));
`ifdef FUNCT_GENERATOR_FIFO_FWFT_EN
      chk("tbl_data", data_o, tbl[i].data_fwft);
`else
      chk("tbl_data", data_o, tbl[i].data_std);
`endif
    end
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clr_err_i = 1'b0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
    last_data = 32'h55;

    // Wrap-around at steady count 3.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Leave an error pending, reach count 9, then reset mid-operation.
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd9);
    do_reset();
    step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
`ifndef FUNCT_GENERATOR_FIFO_FWFT_EN
    chk("post_rst_data", data_o, 32'hA5A5A5A5);
`endif

`ifdef FUNCT_GENERATOR_FIFO_FWFT_EN
    do_reset();
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    chk("fwft_empty", 32'(empty_o), 32'h0);
    chk("fwft_word", data_o, 32'h12345678);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(empty_o), 32'h1);
    chk("fwft_pop_data", data_o, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
